// File: rtl/seg_scan_if.sv
// Signal bundle between the scan controller, the shared bin_to_seg decoder and the display pins.
// master = the scan controller; slave = the surrounding board logic.
interface seg_scan_if;
   logic [15:0] digits;
   logic        blank_lz;
   logic        blink_en;
   logic        colon_en;
   logic [6:0]  seg_in;
   logic [3:0]  dig_bin;
   logic [6:0]  seg_out;
   logic [3:0]  an;
   logic        dp;

   modport master (
      input  digits, blank_lz, blink_en, colon_en, seg_in,
      output dig_bin, seg_out, an, dp
   );

   modport slave (
      output digits, blank_lz, blink_en, colon_en, seg_in,
      input  dig_bin, seg_out, an, dp
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-aligned capture,
// leading-zero blanking, whole-display blink and a colon on digit 2.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV  = 50000,
   parameter int DEAD         = 2,
   parameter int BLINK_FRAMES = 64
) (
   input logic       clk,
   input logic       rst,
   seg_scan_if.master bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [FRM_W-1:0] frm_q, frm_d;
   logic             phase_q, phase_d;

   logic tick, frame_end;
   logic dead_done, lz_blank, blink_blank, visible;

   assign tick      = (cnt_q == CNT_LAST);
   assign frame_end = tick && (idx_q == 2'd3);

   // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d    = tick ? idx_q + 2'd1 : idx_q;
      shadow_d = frame_end ? bus.digits : shadow_q;
      frm_d    = frm_q;
      phase_d  = phase_q;
      if (frame_end) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + FRM_W'(1);
         end
      end
   end

   // NOTE: reset is synchronous and wins over every other update; state uses non-blocking assignment.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         frm_q    <= '0;
         phase_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         frm_q    <= frm_d;
         phase_q  <= phase_d;
      end
   end

   // With no dead time every cycle of the slot is lit; avoids a trivially-true compare.
   if (DEAD == 0) begin : g_no_dead
      assign dead_done = 1'b1;
   end else begin : g_dead
      assign dead_done = (cnt_q >= CNT_W'(DEAD));
   end

   assign lz_blank    = bus.blank_lz &&
                        (((idx_q == 2'd3) && (shadow_q[15:12] == 4'd0)) ||
                         ((idx_q == 2'd2) && (shadow_q[15:8]  == 8'd0)));
   assign blink_blank = bus.blink_en && phase_q;
   assign visible     = dead_done && !lz_blank && !blink_blank;

   assign bus.dig_bin = shadow_q[{idx_q, 2'b00} +: 4];
   assign bus.an      = visible ? ~(4'b0001 << idx_q) : 4'b1111;
   assign bus.seg_out = visible ? bus.seg_in : 7'b1111111;
   assign bus.dp      = ~(visible && (idx_q == 2'd2) && bus.colon_en);

endmodule
